// File: rtl/arbitro_mux4.sv
// arbitro_mux4: round-robin 4:1 arbiter plus registered data mux; define ARBITRO_TIMEOUT_EN for the MAX_HOLD forced release.
// Latency: grant one edge after req, OUT/valido one edge after grant; at least a 2-cycle gap between grants.
// Backpressure: none downstream; a requester keeps the bus while its req stays high (bounded by MAX_HOLD with timeout).
module arbitro_mux4 #(
  parameter int BITS     = 6,
  parameter int MAX_HOLD = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [BITS-1:0] D0,
  input  logic [BITS-1:0] D1,
  input  logic [BITS-1:0] D2,
  input  logic [BITS-1:0] D3,
  output logic [3:0]      grant,
  output logic [1:0]      sel,
  output logic [BITS-1:0] OUT,
  output logic            valido,
  output logic            ocupado,
  output logic            expirou
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CONCEDE = 2'd1,
    LIBERA  = 2'd2
  } estado_t;

  estado_t         estado, prox;
  logic [1:0]      ultimo;
  logic [1:0]      cand;
  logic [1:0]      vencedor;
  logic            tem_req;
  logic            entra;
  logic            fim_tempo;
  logic [BITS-1:0] dado_sel;

  // Search starts right after the last winner, so it drops to lowest priority.
  always_comb begin
    cand     = 2'd0;
    vencedor = ultimo;
    tem_req  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ultimo + k[1:0];
      if (!tem_req && req[cand]) begin
        vencedor = cand;
        tem_req  = 1'b1;
      end
    end
  end

  assign entra = (estado == OCIOSO) && tem_req;

  always_comb begin
    case (sel)
      2'd0:    dado_sel = D0;
      2'd1:    dado_sel = D1;
      2'd2:    dado_sel = D2;
      default: dado_sel = D3;
    endcase
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (tem_req) prox = CONCEDE;
      CONCEDE: if (!req[sel] || fim_tempo) prox = LIBERA;
      LIBERA:  prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      grant  <= '0;
      sel    <= '0;
      ultimo <= 2'd3;
      OUT    <= '0;
      valido <= 1'b0;
    end else begin
      estado <= prox;
      valido <= (estado == CONCEDE);
      if (estado == CONCEDE) OUT <= dado_sel;
      if (entra) begin
        sel    <= vencedor;
        ultimo <= vencedor;
        grant  <= 4'b0001 << vencedor;
      end else if (prox != CONCEDE) begin
        grant  <= '0;
      end
    end
  end

  assign ocupado = (estado != OCIOSO);

`ifdef ARBITRO_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] cnt;

  // A release on the same edge wins over the timeout, so expirou needs req[sel] still high.
  assign fim_tempo = (estado == CONCEDE) && req[sel] && (cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      expirou <= 1'b0;
    end else begin
      expirou <= fim_tempo;
      if (entra)
        cnt <= '0;
      else if ((estado == CONCEDE) && (cnt != {CW{1'b1}}))
        cnt <= cnt + 1'b1;
    end
  end
`else
  assign fim_tempo = 1'b0;
  assign expirou   = 1'b0;

  if (MAX_HOLD < 1) begin : g_max_hold_invalido
  end
`endif

endmodule

// File: tb/tb_arbitro_mux4.sv
// Bench for arbitro_mux4: directed steps from the test plan, then random traffic, all checked against a transaction-level model.
module tb_arbitro_mux4;
  localparam int BITS     = 6;
  localparam int MAX_HOLD = 3;
`ifdef ARBITRO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [BITS-1:0] d [4];
  logic [3:0]      grant;
  logic [1:0]      sel;
  logic [BITS-1:0] OUT;
  logic            valido, ocupado, expirou;

  arbitro_mux4 #(.BITS(BITS), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset(reset), .req(req),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .grant(grant), .sel(sel), .OUT(OUT),
    .valido(valido), .ocupado(ocupado), .expirou(expirou)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the bus, how many dead edges remain, how long the owner has held it.
  int              m_owner, m_gap, m_len, m_last;
  logic [1:0]      m_sel;
  logic [BITS-1:0] m_out;
  logic            m_valido, m_expirou;

  int         order[$];
  int         outs[$];
  int         exp_order[5];
  int         exp_outs[8];
  logic [3:0] exp_tg[10];
  logic       exp_te[10];
  logic [3:0] r, pg, rmask;

  function automatic int rr_pick(input int last, input logic [3:0] rq);
    for (int k = 1; k <= 4; k++)
      if (rq[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (reset) begin
      m_owner = -1; m_gap = 0; m_len = 0; m_last = 3;
      m_sel = 2'd0; m_out = '0; m_valido = 1'b0; m_expirou = 1'b0;
      return;
    end
    m_expirou = 1'b0;
    m_valido  = (m_owner >= 0);
    if (m_owner >= 0) begin
      m_out = d[m_owner];
      if (!req[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (TO_EN && m_len == MAX_HOLD) begin
        m_owner = -1; m_gap = 1; m_expirou = 1'b1;
      end else begin
        m_len++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      w = rr_pick(m_last, req);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_sel = 2'(w); m_len = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk({tag, ".grant"},   32'(grant),   32'(eg));
    chk({tag, ".sel"},     32'(sel),     32'(m_sel));
    chk({tag, ".OUT"},     32'(OUT),     32'(m_out));
    chk({tag, ".valido"},  32'(valido),  32'(m_valido));
    chk({tag, ".ocupado"}, 32'(ocupado), 32'((m_owner >= 0) || (m_gap > 0)));
    chk({tag, ".expirou"}, 32'(expirou), 32'(m_expirou));
  endtask

  // Drive inputs away from the edge, predict, then sample 1 time unit after the edge.
  task automatic cyc(input logic [3:0] rq, input string tag);
    req = rq;
    model_edge();
    @(posedge clock);
    #1;
    check_all(tag);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    d     = '{6'd0, 6'd0, 6'd0, 6'd0};

    // Reset, then idle.
    cyc(4'b0000, "rst");
    cyc(4'b0000, "rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(4'b0000, "idle");
    chk("idle_grant", 32'(grant), 32'd0);

    // All four requesting, each dropping after two grant cycles.
    d  = '{6'd1, 6'd2, 6'd3, 6'd4};
    pg = 4'b0000;
    for (int c = 0; c < 24; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_len == 2) r[m_owner] = 1'b0;
      cyc(r, "rr4");
      if (grant != 4'b0000 && pg == 4'b0000) order.push_back(int'(sel));
      if (valido && outs.size() < 8) outs.push_back(int'(OUT));
      pg = grant;
    end
    exp_order = '{0, 1, 2, 3, 0};
    exp_outs  = '{1, 1, 2, 2, 3, 3, 4, 4};
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
    for (int i = 0; i < 8; i++)
      chk("rr_out", (i < outs.size()) ? 32'(outs[i]) : 32'hFFFF_FFFF, 32'(exp_outs[i]));

    // Single requester 2.
    for (int i = 0; i < 3; i++) cyc(4'b0000, "drain");
    d[2] = 6'h2A;
    cyc(4'b0100, "r2");
    chk("r2_grant", 32'(grant), 32'b0100);
    chk("r2_sel",   32'(sel),   32'd2);
    cyc(4'b0100, "r2");
    chk("r2_out",    32'(OUT),    32'h2A);
    chk("r2_valido", 32'(valido), 32'd1);
    cyc(4'b0000, "r2");
    cyc(4'b0000, "r2");

    reset = 1'b1;
    cyc(4'b0000, "rst2");
    reset = 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
    // Two holders that never let go: forced release every MAX_HOLD cycles.
    exp_tg = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
               4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    exp_te = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0011, "tmo");
      chk("tmo_grant",   32'(grant),   32'(exp_tg[i]));
      chk("tmo_expirou", 32'(expirou), 32'(exp_te[i]));
    end
`else
    // Without timeout a lone holder keeps the bus indefinitely.
    cyc(4'b0001, "hold");
    for (int i = 0; i < 40; i++) begin
      cyc(4'b0001, "hold");
      chk("hold_grant",   32'(grant),   32'b0001);
      chk("hold_expirou", 32'(expirou), 32'd0);
    end
`endif
    for (int i = 0; i < 3; i++) cyc(4'b0000, "drain");

    // Reset during the second grant cycle of requester 3.
    d[3] = 6'h15;
    cyc(4'b1000, "r3");
    cyc(4'b1000, "r3");
    chk("r3_grant_pre", 32'(grant), 32'b1000);
    reset = 1'b1;
    cyc(4'b1000, "r3rst");
    chk("r3rst_grant",   32'(grant),   32'd0);
    chk("r3rst_sel",     32'(sel),     32'd0);
    chk("r3rst_out",     32'(OUT),     32'd0);
    chk("r3rst_valido",  32'(valido),  32'd0);
    chk("r3rst_ocupado", 32'(ocupado), 32'd0);
    reset = 1'b0;
    cyc(4'b1000, "r3again");
    chk("r3again_grant", 32'(grant), 32'b1000);
    chk("r3again_sel",   32'(sel),   32'd3);
    cyc(4'b1001, "r3again");
    cyc(4'b0001, "r3rel");
    cyc(4'b0001, "r3rel");
    cyc(4'b0001, "r0next");
    chk("r0next_grant", 32'(grant), 32'b0001);

    // Random traffic with occasional resets.
    rmask = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) rmask[b] = ~rmask[b];
        d[b] = BITS'($urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      cyc(rmask, "rand");
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
